// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 packet controller.
//   frame_state_e : framing FSM states (BYTE1/BYTE2/BYTE3)
//   PKT_W         : width of one assembled packet (three bytes)
//   SYNC_BIT      : bit of the first byte that is always 1 on a valid packet
//   FIFO_DEPTH    : number of packets the output FIFO can hold
//   pack_pkt      : concatenates three bytes into a packet, byte1 in the MSBs
package ps2_pkg;

  typedef enum logic [1:0] {
    BYTE1 = 2'd0,
    BYTE2 = 2'd1,
    BYTE3 = 2'd2
  } frame_state_e;

  localparam int PKT_W      = 24;
  localparam int SYNC_BIT   = 3;
  localparam int FIFO_DEPTH = 2;

  function automatic logic [PKT_W-1:0] pack_pkt(input logic [7:0] b1,
                                                input logic [7:0] b2,
                                                input logic [7:0] b3);
    return {b1, b2, b3};
  endfunction

endpackage

// File: rtl/ps2_pkt_fifo.sv
// Two-entry packet FIFO feeding the consumer side of ps2_packet_ctrl.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   push, push_data: write request and packet; accepted when not full or
//                    when a pop happens in the same cycle
//   pop            : remove the head (ignored when empty)
//   head           : current head packet, 0 when empty
//   full, empty    : occupancy flags, both straight from the count register
module ps2_pkt_fifo
  import ps2_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [PKT_W-1:0] push_data,
  input  logic             pop,
  output logic [PKT_W-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A pop frees the slot under rd_ptr, which equals wr_ptr when full, so a
  // simultaneous push can reuse it safely.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_packet_ctrl.sv
// PS/2 mouse packet framer: groups incoming bytes into 3-byte packets,
// resynchronises on a bad first byte or an inter-byte timeout, and queues
// finished packets in a 2-entry FIFO.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_byte      : received byte, valid when in_valid is high (one-cycle strobe)
//   pkt_data     : head packet {byte1, byte2, byte3}, 0 when no packet waits
//   pkt_valid    : head packet available
//   pkt_ready    : consumer accepts the head
//   drop_cnt     : packets lost to a full FIFO, saturates at 255
//   sync_err     : one-cycle pulse, first byte rejected (sync bit clear)
//   timeout_err  : one-cycle pulse, partial packet abandoned after idling
//   fsm_state    : current framing state, for observation
// Handshake: a packet transfers on every rising edge where pkt_valid and
// pkt_ready are both high; while pkt_valid is high and pkt_ready is low the
// head (pkt_data) is held unchanged. pkt_valid never depends on pkt_ready.
module ps2_packet_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [7:0]       drop_cnt,
  output logic             sync_err,
  output logic             timeout_err,
  output frame_state_e     fsm_state
);

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  frame_state_e state_q;
  logic [7:0]   byte1_q;
  logic [7:0]   byte2_q;
  logic [15:0]  idle_q;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         drop;

  assign push      = (state_q == BYTE3) && in_valid;
  assign pop       = pkt_valid && pkt_ready;
  assign pkt_valid = !fifo_empty;
  // A pop in the same cycle makes room, so only a push against a full FIFO
  // with no pop loses the packet.
  assign drop      = push && fifo_full && !pop;
  assign fsm_state = state_q;

  ps2_pkt_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pack_pkt(byte1_q, byte2_q, in_byte)),
    .pop       (pop),
    .head      (pkt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BYTE1;
      byte1_q     <= '0;
      byte2_q     <= '0;
      idle_q      <= '0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        BYTE1: begin
          idle_q <= '0;
          if (in_valid) begin
            if (in_byte[SYNC_BIT]) begin
              byte1_q <= in_byte;
              state_q <= BYTE2;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        BYTE2, BYTE3: begin
          // An arriving byte always beats the timeout on the same cycle.
          if (in_valid) begin
            idle_q <= '0;
            if (state_q == BYTE2) begin
              byte2_q <= in_byte;
              state_q <= BYTE3;
            end else begin
              state_q <= BYTE1;
            end
          end else if (idle_q == IDLE_LAST) begin
            idle_q      <= '0;
            byte1_q     <= '0;
            byte2_q     <= '0;
            state_q     <= BYTE1;
            timeout_err <= 1'b1;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
        default: begin
          state_q <= BYTE1;
          idle_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/ps2_packet_ctrl.md
PS2_PACKET_CTRL -- requirements
Module: ps2_packet_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, idle cycles allowed between bytes of one packet before resync (legal 2..65535).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_byte  input  8  received PS/2 byte, qualified by in_valid.
REQ-005 in_valid  input  1  one-cycle strobe, in_byte accepted this cycle.
REQ-006 pkt_data  output  24  head packet, {byte1, byte2, byte3}, byte1 in [23:16].
REQ-007 pkt_valid  output  1  head packet available.
REQ-008 pkt_ready  input  1  consumer accepts head when pkt_valid is high.
REQ-009 drop_cnt  output  8  count of packets lost to overflow, saturating.
REQ-010 sync_err  output  1  one-cycle pulse, byte discarded in BYTE1 because in_byte[3]=0.
REQ-011 timeout_err  output  1  one-cycle pulse, partial packet abandoned on timeout.

Function
REQ-012 Framing FSM SHALL have states BYTE1, BYTE2, BYTE3; it advances only on cycles with in_valid=1, except for timeout.
REQ-013 BYTE1 + in_valid: if in_byte[3]=1, capture as byte1 and go to BYTE2; otherwise stay in BYTE1 and pulse sync_err on the next cycle.
REQ-014 BYTE2 + in_valid: capture byte2 and go to BYTE3; bit 3 is not checked.
REQ-015 BYTE3 + in_valid: form {byte1, byte2, in_byte}, push it to the output FIFO, and go to BYTE1.
REQ-016 Idle counter: cleared on every accepted byte and on entry to BYTE1; increments each cycle in BYTE2/BYTE3 without in_valid.
REQ-017 In BYTE2/BYTE3 with in_valid=0 and idle counter = TIMEOUT-1, the FSM SHALL go to BYTE1, discard partial bytes, and pulse timeout_err next cycle.
REQ-018 in_valid on the timeout cycle wins: the byte is accepted normally and no timeout occurs.
REQ-019 Output FIFO: 2 entries of 24 bits; pkt_data/pkt_valid reflect the head.
REQ-020 Latency: pkt_valid SHALL assert the cycle after the third byte is accepted into an empty FIFO.
REQ-021 Pop on pkt_valid && pkt_ready; pkt_data stable while pkt_valid=1 and pkt_ready=0.
REQ-022 Push into a full FIFO with a pop in the same cycle SHALL succeed; push into a full FIFO without a pop SHALL drop the new packet and increment drop_cnt.
REQ-023 drop_cnt SHALL saturate at 255 and clear only on reset.
REQ-024 Simultaneous push and pop on a 1-entry FIFO SHALL leave occupancy at 1, with the new packet becoming the head.
REQ-025 pkt_data SHALL read 0 when the FIFO is empty.

Reset
REQ-026 Reset SHALL immediately force state=BYTE1, FIFO empty, pkt_valid=0, pkt_data=0, drop_cnt=0, sync_err=0, timeout_err=0, and idle counter=0.
REQ-027 Reset mid-packet SHALL discard the partial packet; FIFO contents are lost and no packet is emitted.
REQ-028 First byte is accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package ps2_pkg SHALL hold: the framing state enum typedef (BYTE1/BYTE2/BYTE3), PKT_W=24, and the sync-bit index constant SYNC_BIT=3.
REQ-030 The FIFO SHALL be sub-module ps2_pkt_fifo (2-deep, 24-bit, push/pop/full/empty); framing FSM, idle counter and error/drop logic stay in ps2_packet_ctrl.

Verification
REQ-031 Bytes 0x08, 0x12, 0x34 with pkt_ready=1 -> pkt_valid=1 for one cycle with pkt_data=0x081234, the cycle after 0x34.
REQ-032 Bytes 0x00, 0x05, then 0x09, 0xAA, 0xBB -> two sync_err pulses, then one packet 0x09AABB.
REQ-033 TIMEOUT=4; bytes 0x08, 0x11, then 4 idle cycles, then 0x08, 0x22, 0x33 -> one timeout_err, single packet 0x082233.
REQ-034 pkt_ready=0; push 3 packets -> FIFO holds first two, drop_cnt=1; then pkt_ready=1 -> first two packets drain in order.
REQ-035 Assert reset after 2 bytes of a packet, then send 0x18, 0x01, 0x02 -> outputs zero during reset, then single packet 0x180102.
REQ-036 pkt_ready=0 with 300 overflow packets -> drop_cnt holds at 255.
